// File: rtl/pcg_dxsm_bounded_if.sv
// Request/response bundle between a ranged-random client and pcg_dxsm_bounded.
// The client drives the master side; the sampler implements the slave side.
interface pcg_dxsm_bounded_if #(
    parameter int unsigned REJ_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [63:0]      req_bound;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_value;
    logic [REJ_W-1:0] rsp_rejects;

    modport master (
        output req_valid, req_bound, rsp_ready,
        input  req_ready, rsp_valid, rsp_value, rsp_rejects
    );

    modport slave (
        input  req_valid, req_bound, rsp_ready,
        output req_ready, rsp_valid, rsp_value, rsp_rejects
    );
endinterface

// File: rtl/pcg_dxsm_bounded.sv
// Unbiased [0, s) sampler over a pcg_dxsm word stream (Lemire multiply-and-reject).
// The rejection threshold (2^64 - s) mod s is computed serially and cached per bound.
module pcg_dxsm_bounded #(
    parameter int unsigned REJ_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    pcg_dxsm_bounded_if.slave        bus,
    output logic                     o_gen_en,
    input  logic [63:0]              i_gen_data
);
    localparam int unsigned DW    = 64;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [2:0] {
        S_IDLE, S_DIV, S_FETCH, S_CAPT, S_CHECK, S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [DW-1:0]      r_s;
    logic               r_pass;
    logic               r_cache_valid;
    logic [DW-1:0]      r_cache_bound;
    logic [DW-1:0]      r_t;
    logic [DW-1:0]      r_rem;
    logic [DW-1:0]      r_dvd;
    logic [CNT_W-1:0]   r_cnt;
    logic [DW-1:0]      r_x;
    logic [2*DW-1:0]    r_m;
    logic [REJ_W-1:0]   r_rej;
    logic               r_req_ready;
    logic               r_gen_en;
    logic               r_rsp_valid;
    logic [DW-1:0]      r_rsp_value;

    logic [DW:0]        w_rem_shift;
    logic               w_rem_ge;
    logic [DW-1:0]      w_rem_nxt;
    logic               w_reject;
    logic               w_accept;
    logic               w_hit;
    logic               w_div_last;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        w_rem_shift = {r_rem, r_dvd[DW-1]};
        w_rem_ge    = (w_rem_shift >= {1'b0, r_s});
        w_rem_nxt   = w_rem_ge ? DW'(w_rem_shift - {1'b0, r_s}) : w_rem_shift[DW-1:0];
        w_reject    = (r_m[DW-1:0] < r_t);
        w_accept    = bus.req_valid && r_req_ready;
        w_hit       = r_cache_valid && (bus.req_bound == r_cache_bound);
        w_div_last  = (r_cnt == CNT_W'(DW - 1));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)
                         w_state_nxt = ((bus.req_bound == '0) || w_hit) ? S_FETCH : S_DIV;
            S_DIV:   if (w_div_last) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_CAPT;
            S_CAPT:  w_state_nxt = S_CHECK;
            S_CHECK: w_state_nxt = (!r_pass && w_reject) ? S_FETCH : S_RESP;
            S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_s           <= '0;
            r_pass        <= 1'b0;
            r_cache_valid <= 1'b0;
            r_cache_bound <= '0;
            r_t           <= '0;
            r_rem         <= '0;
            r_dvd         <= '0;
            r_cnt         <= '0;
            r_x           <= '0;
            r_m           <= '0;
            r_rej         <= '0;
            r_req_ready   <= 1'b1;
            r_gen_en      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_value   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == S_IDLE);
            r_gen_en    <= (w_state_nxt == S_FETCH);
            r_rsp_valid <= (w_state_nxt == S_RESP);
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_s    <= bus.req_bound;
                    r_pass <= (bus.req_bound == '0);
                    r_rej  <= '0;
                    r_rem  <= '0;
                    r_dvd  <= ~bus.req_bound + DW'(1);
                    r_cnt  <= '0;
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= {r_dvd[DW-2:0], 1'b0};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_div_last) begin
                        r_t           <= w_rem_nxt;
                        r_cache_bound <= r_s;
                        r_cache_valid <= 1'b1;
                    end
                end
                S_CAPT: begin
                    r_x <= i_gen_data;
                    r_m <= (2*DW)'(i_gen_data) * (2*DW)'(r_s);
                end
                S_CHECK: begin
                    if (r_pass)
                        r_rsp_value <= r_x;
                    else if (w_reject) begin
                        if (r_rej != '1) r_rej <= r_rej + REJ_W'(1);
                    end else
                        r_rsp_value <= r_m[2*DW-1:DW];
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_value   = r_rsp_value;
    assign bus.rsp_rejects = r_rej;
    assign o_gen_en        = r_gen_en;
endmodule

// File: tb/tb_pcg_dxsm_bounded.sv
// Directed-vector bench for pcg_dxsm_bounded with a word-stream generator stub
// and a behavioural pcg_dxsm stream feeding a software Lemire model.
module tb_pcg_dxsm_bounded;
    localparam logic [127:0] PCG_MULT = 128'h2360ED051FC65DA44385DF649FCCF645;
    localparam logic [127:0] PCG_INC  = 128'h5851F42D4C957F2D14057B7EF767814F;
    localparam logic [63:0]  DXSM_MUL = 64'hDA942042E4DD58B5;
    localparam logic [127:0] SEED     = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [63:0]  ONES     = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0]  MSB      = 64'h8000_0000_0000_0000;

    typedef struct packed {
        logic [63:0]       bound;
        logic [31:0]       nw;
        logic [2:0][63:0]  w;
        logic [63:0]       val;
        logic [63:0]       rej;
        logic [31:0]       lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gen_en;
    logic [63:0] gen_data = '0;
    logic [63:0] stream [2048];
    int unsigned gen_cnt = 0;
    int unsigned base = 0;
    int          n_pass = 0;
    int          n_total = 0;

    pcg_dxsm_bounded_if #(.REJ_W(8)) bus ();

    pcg_dxsm_bounded #(.REJ_W(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (bus),
        .o_gen_en   (gen_en),
        .i_gen_data (gen_data)
    );

    always #5 clk = ~clk;

    // Generator stub: the word for each enable pulse appears on the following cycle.
    always @(posedge clk) begin
        if (gen_en) begin
            gen_data <= stream[11'(gen_cnt - base)];
            gen_cnt  <= gen_cnt + 1;
        end
    end

    function automatic logic [63:0] pcg_out(input logic [127:0] st);
        logic [63:0] hi, lo;
        hi = st[127:64];
        lo = st[63:0] | 64'd1;
        hi = hi ^ (hi >> 32);
        hi = hi * DXSM_MUL;
        hi = hi ^ (hi >> 48);
        hi = hi * lo;
        return hi;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    endtask

    task automatic load_words(input int nw, input logic [2:0][63:0] w);
        base = gen_cnt;
        for (int i = 0; i < nw; i++) stream[i] = w[i];
    endtask

    // Issue one request, optionally stall the response, then complete the handshake.
    task automatic run_req(input logic [63:0] bound, input int hold,
                           output logic [63:0] val, output logic [63:0] rej,
                           output int lat, output int pulses);
        int unsigned c0;
        @(negedge clk);
        bus.req_bound = bound;
        bus.req_valid = 1'b1;
        c0 = gen_cnt;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_bound = 64'hA5A5_5A5A_0F0F_F0F0;
        lat = 1;
        while (!bus.rsp_valid && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
        end
        val = bus.rsp_value;
        rej = 64'(bus.rsp_rejects);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_rsp_valid",   64'(bus.rsp_valid), 64'd1);
            check("bp_rsp_value",   bus.rsp_value, val);
            check("bp_rsp_rejects", 64'(bus.rsp_rejects), rej);
            check("bp_req_ready",   64'(bus.req_ready), 64'd0);
            check("bp_gen_en",      64'(gen_en), 64'd0);
        end
        pulses = int'(gen_cnt - c0);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("idle_req_ready", 64'(bus.req_ready), 64'd1);
        check("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},   64'(bus.req_ready), 64'd1);
        check({tag, "_gen_en"},      64'(gen_en), 64'd0);
        check({tag, "_rsp_valid"},   64'(bus.rsp_valid), 64'd0);
        check({tag, "_rsp_value"},   bus.rsp_value, 64'd0);
        check({tag, "_rsp_rejects"}, 64'(bus.rsp_rejects), 64'd0);
    endtask

    function automatic vec_t mk(input logic [63:0] b, input int nw,
                                input logic [63:0] w0, input logic [63:0] w1,
                                input logic [63:0] w2, input logic [63:0] val,
                                input logic [63:0] rej, input int lat);
        vec_t v;
        v.bound = b;   v.nw = 32'(nw);
        v.w[0] = w0;   v.w[1] = w1;   v.w[2] = w2;
        v.val = val;   v.rej = rej;   v.lat = 32'(lat);
        return v;
    endfunction

    initial begin
        vec_t        vecs [10];
        logic [63:0] v, rj, t, x, mv, mr;
        logic [127:0] st, m;
        int          lat, pl, mi;
        logic [2:0][63:0] ws;

        bus.req_valid = 1'b0;
        bus.req_bound = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 2048; i++) stream[i] = '0;

        vecs[0] = mk(64'd3,  2, 64'd0, MSB, 64'd0,                          64'd1, 64'd1, 71);
        vecs[1] = mk(64'd3,  1, 64'd5, 64'd0, 64'd0,                        64'd0, 64'd0, 4);
        vecs[2] = mk(64'd0,  1, 64'hDEAD_BEEF_0123_4567, 64'd0, 64'd0,
                     64'hDEAD_BEEF_0123_4567, 64'd0, 4);
        vecs[3] = mk(64'd3,  1, 64'd7, 64'd0, 64'd0,                        64'd0, 64'd0, 4);
        vecs[4] = mk(MSB,    1, ONES, 64'd0, 64'd0,      64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 68);
        vecs[5] = mk(64'd1,  1, 64'h1234, 64'd0, 64'd0,                     64'd0, 64'd0, 68);
        vecs[6] = mk(64'd10, 2, 64'd0, ONES, 64'd0,                         64'd9, 64'd1, 71);
        vecs[7] = mk(64'd10, 2, 64'h1999_9999_9999_999A, 64'd2, 64'd0,      64'd0, 64'd1, 7);
        vecs[8] = mk(ONES,   2, 64'd0, ONES, 64'd0,      64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 71);
        vecs[9] = mk(64'd6,  2, 64'hAAAA_AAAA_AAAA_AAAB, ONES, 64'd0,       64'd5, 64'd1, 71);

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            load_words(int'(vecs[i].nw), vecs[i].w);
            run_req(vecs[i].bound, 0, v, rj, lat, pl);
            check($sformatf("v%0d_value", i),   v, vecs[i].val);
            check($sformatf("v%0d_rejects", i), rj, vecs[i].rej);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_gen_pulses", i), 64'(pl), vecs[i].rej + 64'd1);
        end

        // Backpressure on a cache hit (t = 4 for s = 6; 3*6 = 18 accepted).
        ws = '0; ws[0] = 64'd3;
        load_words(1, ws);
        run_req(64'd6, 10, v, rj, lat, pl);
        check("bp_value",   v, 64'd0);
        check("bp_latency", 64'(lat), 64'd4);

        // Saturating reject counter: 300 zero words rejected, then accept.
        base = gen_cnt;
        for (int i = 0; i < 300; i++) stream[i] = 64'd0;
        stream[300] = ONES;
        run_req(64'd6, 0, v, rj, lat, pl);
        check("sat_value",   v, 64'd5);
        check("sat_rejects", rj, 64'd255);
        check("sat_latency", 64'(lat), 64'd904);
        check("sat_pulses",  64'(pl), 64'd301);

        // Reset in cycle 30 of a miss, then the miss path again.
        @(negedge clk);
        bus.req_bound = 64'd3;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int i = 1; i < 30; i++) begin
            @(posedge clk); #1;
        end
        check("div_gen_en",    64'(gen_en), 64'd0);
        check("div_req_ready", 64'(bus.req_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("middiv");
        rst = 1'b0;
        ws = '0; ws[0] = MSB;
        load_words(1, ws);
        run_req(64'd3, 0, v, rj, lat, pl);
        check("post_rst_value",   v, 64'd1);
        check("post_rst_latency", 64'(lat), 64'd68);

        // Reset while idle must drop the cached bound of 3.
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("idle_rst");
        rst = 1'b0;
        ws = '0; ws[0] = 64'd5;
        load_words(1, ws);
        run_req(64'd3, 0, v, rj, lat, pl);
        check("inval_value",   v, 64'd0);
        check("inval_latency", 64'(lat), 64'd68);

        // Behavioural pcg_dxsm stream against a software Lemire model.
        st = SEED;
        for (int i = 0; i < 2048; i++) begin
            stream[i] = pcg_out(st);
            st = st * PCG_MULT + PCG_INC;
        end
        base = gen_cnt;
        mi = 0;
        t = (~64'd1000 + 64'd1) % 64'd1000;
        for (int r = 0; r < 100; r++) begin
            mr = 0;
            mv = 0;
            for (int k = 0; k < 64; k++) begin
                x  = stream[mi];
                mi++;
                m  = 128'(x) * 128'd1000;
                if (m[63:0] < t) mr++;
                else begin
                    mv = m[127:64];
                    break;
                end
            end
            run_req(64'd1000, 0, v, rj, lat, pl);
            check($sformatf("pcg%0d_range", r),   64'(v < 64'd1000), 64'd1);
            check($sformatf("pcg%0d_value", r),   v, mv);
            check($sformatf("pcg%0d_rejects", r), rj, mr);
        end
        check("pcg_words_consumed", 64'(gen_cnt - base), 64'(mi));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pcg_dxsm_bounded.md
# pcg_dxsm_bounded

Unbiased bounded-range sampler that consumes the 64-bit output stream of `pcg_dxsm` and returns integers uniformly distributed in [0, bound). It implements Lemire's multiply-and-reject method:

- an iterative remainder unit computes the rejection threshold;
- a one-word cache skips that step for repeated bounds.

It sits between the `pcg_dxsm` generator, whose `en` input it drives, and any client needing ranged random values, with valid/ready on both request and response sides.

## Interface
- `REJ_W`, default 8: width of the per-response rejection counter, which saturates at 2^REJ_W−1.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: a request with `req_bound` is presented.
- `req_ready` out 1: block can accept a request; high only in IDLE.
- `req_bound` in 64: exclusive upper bound s. The value 0 means full 64-bit range (passthrough).
- `gen_en` out 1: enable to `pcg_dxsm`; one-cycle pulse per word requested.
- `gen_data` in 64: `pcg_dxsm` output; holds the new word in the cycle after `gen_en` was high.
- `rsp_valid` out 1: result valid; held until accepted.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_value` out 64: sampled value in [0, s), or the raw word when s = 0.
- `rsp_rejects` out REJ_W: number of words discarded for this response.

## Operation
- **States:** IDLE, DIV, FETCH, CAPT, CHECK, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`&&`req_ready`: latch s, clear the reject counter, then go to:
    - FETCH with the passthrough flag set if s = 0;
    - FETCH if the cache is valid and s equals the cached bound;
    - DIV otherwise.
- **DIV**
  - Computes t = (2^64 − s) mod s as a 64-iteration restoring division.
  - The dividend is (~s + 1) in 64 bits; the partial remainder is 65 bits wide.
  - One quotient bit per cycle; the quotient is discarded.
  - After exactly 64 cycles: store t, the cached bound = s, set cache-valid, go to FETCH.
- **FETCH:** `gen_en` = 1 for this single cycle, then go to CAPT.
- **CAPT:** register x = `gen_data` and the 128-bit product m = x·s, then go to CHECK.
- **CHECK**
  - Passthrough: result = x.
  - Else if m[63:0] < t: increment the reject counter (saturating) and go to FETCH.
  - Else: result = m[127:64], go to RESP.
- **RESP:** `rsp_valid` = 1, with `rsp_value` and `rsp_rejects` stable; on `rsp_ready`, go to IDLE.
- **Arithmetic:** all comparisons are unsigned.
- **s = 1:** t = 0, so there is never a rejection and the value is always 0.
- **s a power of two:** t = 0, so there is never a rejection.

## Timing
- **Reset values:** state IDLE, `req_ready` = 1, `gen_en` = 0, `rsp_valid` = 0, `rsp_value` = 0, `rsp_rejects` = 0, cache-valid = 0, t = 0.
- **Cycle numbering:** the accept cycle is cycle 0.
- **Cache hit or passthrough, no rejection:** FETCH at cycle 1, CAPT at 2, CHECK at 3, `rsp_valid` first high at cycle 4.
- **Cache miss:** DIV occupies cycles 1–64 and `rsp_valid` is first high at cycle 68.
- **Each rejection:** adds 3 cycles.
- **`gen_en`:** never high outside FETCH; exactly one generator word is consumed per FETCH.
- **Response handshake:** completes in the cycle where `rsp_valid`&&`rsp_ready`; IDLE and `req_ready` follow on the next cycle. A request and a response never overlap.
- **Reset mid-operation** (any state): the next cycle is IDLE with the reset values above, and the cache is invalidated. A word already consumed from the generator is lost; this is acceptable.
- **Reject counter:** at 2^REJ_W−1 it holds its value, and the loop continues until acceptance.
- **Held inputs:** `req_bound` changes while not in IDLE are ignored.

## Test plan
- **Fresh bound, one rejection:**
  - After reset, request s = 3; the stub generator supplies 0, then 0x8000_0000_0000_0000.
  - Required: t = 1; the first word is rejected (low 0 < 1); `rsp_value` = 1, `rsp_rejects` = 1; `rsp_valid` first high at cycle 71; exactly 2 `gen_en` pulses.
- **Cache hit:**
  - Immediately request s = 3 again; the generator supplies 5.
  - Required: no DIV; `rsp_value` = 0, `rsp_rejects` = 0; `rsp_valid` at cycle 4.
- **Passthrough and power-of-two bound:**
  - s = 0 with generator word 0xDEAD_BEEF_0123_4567 gives `rsp_value` = 0xDEAD_BEEF_0123_4567 at cycle 4.
  - s = 2^63 with word 0xFFFF_FFFF_FFFF_FFFF gives `rsp_value` = 0x7FFF_FFFF_FFFF_FFFF with 0 rejects.
- **Backpressure:**
  - Hold `rsp_ready` = 0 for 10 cycles in RESP.
  - Required: `rsp_valid`, `rsp_value` and `rsp_rejects` stay stable; `req_ready` = 0; no `gen_en` pulses.
  - Release: IDLE one cycle after the handshake.
- **Reset mid-DIV:**
  - Assert `rst` at cycle 30 of a s = 3 request.
  - Required: all outputs at reset values next cycle. A following s = 3 request takes the miss path, with `rsp_valid` at cycle 68.
- **Integration with `pcg_dxsm`:**
  - Use the real generator with seed 0x0123456789ABCDEF_FEDCBA9876543210 and s = 1000 for 100 requests.
  - Required: every `rsp_value` < 1000, and each matches a software Lemire model fed the same stream.
